// File: rtl/sb_ctrl.sv
// Store-buffer controller: circular entry allocation, out-of-order writeback capture,
// in-order retirement tracking and a two-state valid/ready drain of retired stores.
module sb_ctrl #(
  parameter  int SB_ENTRY = 8,
  parameter  int ADDR_W   = 16,
  parameter  int DATA_W   = 16,
  localparam int PTR_W    = $clog2(SB_ENTRY),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              alloc_v_i,
  output logic              alloc_ready_o,
  output logic [PTR_W-1:0]  alloc_num_o,
  input  logic              wb_v_i,
  input  logic [PTR_W-1:0]  wb_num_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              retire_v_i,
  input  logic              flush_i,
  output logic              mem_v_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [SB_ENTRY-1:0] sb_wb_vector_o,
  output logic [PTR_W-1:0]  sb_commit_pt_o,
  output logic              sb_empty_o
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    head_q, ret_q, tail_q;
  logic [PTR_W-1:0]    head_d, ret_d, tail_d;
  logic [CNT_W-1:0]    cnt_q, rcnt_q, cnt_d, rcnt_d;
  logic [SB_ENTRY-1:0] wb_q, wb_d;

  logic [ADDR_W-1:0]   addr_mem [SB_ENTRY];
  logic [DATA_W-1:0]   data_mem [SB_ENTRY];
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_data_q;

  logic                alloc_fire, wb_fire, ret_fire;
  logic                latch_req, drain_acc;
  logic [PTR_W-1:0]    wb_off, spec_off;
  logic [CNT_W-1:0]    spec_len;

  // Ready comes from registered occupancy only; a same-cycle drain never frees a slot early.
  assign alloc_ready_o  = (cnt_q != CNT_W'(SB_ENTRY));
  assign alloc_num_o    = tail_q;
  assign sb_commit_pt_o = head_q;
  assign sb_empty_o     = (cnt_q == '0);
  assign sb_wb_vector_o = wb_q;
  assign mem_v_o        = (state_q == REQ);
  assign mem_addr_o     = mem_addr_q;
  assign mem_data_o     = mem_data_q;

  assign wb_off     = wb_num_i - head_q;
  assign alloc_fire = alloc_v_i & alloc_ready_o & ~flush_i;
  assign wb_fire    = wb_v_i & ~flush_i & ({1'b0, wb_off} < cnt_q);
  assign ret_fire   = retire_v_i & ~flush_i & (rcnt_q != cnt_q);

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    drain_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (rcnt_q != '0) begin
          state_d   = REQ;
          latch_req = 1'b1;
        end
      end
      REQ: begin
        if (mem_ready_i) begin
          drain_acc = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d = head_q + PTR_W'(drain_acc);
    ret_d  = ret_q + PTR_W'(ret_fire);
    rcnt_d = rcnt_q + CNT_W'(ret_fire) - CNT_W'(drain_acc);
    if (flush_i) begin
      tail_d = ret_q;
      cnt_d  = rcnt_d;
    end else begin
      tail_d = tail_q + PTR_W'(alloc_fire);
      cnt_d  = cnt_q + CNT_W'(alloc_fire) - CNT_W'(drain_acc);
    end
  end

  // Flush clears the speculative region ret..tail-1; retired entries keep their bits.
  always_comb begin
    wb_d     = wb_q;
    spec_off = '0;
    spec_len = cnt_q - rcnt_q;
    for (int i = 0; i < SB_ENTRY; i++) begin
      spec_off = PTR_W'(i) - ret_q;
      if (flush_i && ({1'b0, spec_off} < spec_len)) wb_d[i] = 1'b0;
    end
    if (wb_fire)   wb_d[wb_num_i] = 1'b1;
    if (drain_acc) wb_d[head_q]   = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      ret_q   <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      ret_q   <= ret_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      wb_q    <= wb_d;
    end
  end

  // Payload storage and the drain holding register carry no reset.
  always_ff @(posedge clk_i) begin
    if (wb_fire) begin
      addr_mem[wb_num_i] <= wb_addr_i;
      data_mem[wb_num_i] <= wb_data_i;
    end
    if (latch_req) begin
      mem_addr_q <= addr_mem[head_q];
      mem_data_q <= data_mem[head_q];
    end
  end

endmodule
